decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-instruction combinational main decoder.
- Accepts fetched MIPS32 instruction words with their PCs over a valid/ready handshake and decodes each on entry.
- Buffers the decoded control bundles in a DEPTH-entry FIFO and presents the head bundle to the issue/execute side over a second valid/ready handshake.
- Supports pipeline flush and an optional SPECIAL2 MUL extension.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- ENABLE_MUL, 0, 1 = decode SPECIAL2 MUL (op 6'b011100, funct 6'b000010) as legal; 0 = MUL raises ex_ri.
- PC_W, 32, width of the stored PC.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous queue clear (exception/branch redirect).
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry present; equals !empty.
- out_ready  in  1  consumer takes the head this cycle.
- out_pc  out  PC_W  PC of the head entry.
- out_instr  out  32  raw word of the head entry.
- out_regwrite  out  1  GPR write.
- out_regdst  out  2  0 = rt, 1 = rd, 2 = r31.
- out_alusrc  out  1  1 = immediate operand.
- out_branch  out  1  conditional branch.
- out_jump  out  1  J/JAL.
- out_jr  out  1  JR/JALR.
- out_memwrite  out  4  store byte mask class: 4'b1111 SW, 4'b0011 SH, 4'b0001 SB.
- out_memread  out  2  0 none, 1 byte, 2 half, 3 word.
- out_load_signed  out  1  0 for LBU/LHU, else 1.
- out_hilowrite  out  1  MTHI/MTLO/MULT(U)/DIV(U).
- out_cp0write  out  1  MTC0.
- out_cp0read  out  1  MFC0.
- out_ex_ri  out  1  reserved instruction.
- out_ex_bp  out  1  BREAK.
- out_ex_sys  out  1  SYSCALL.
- out_eret  out  1  ERET (exactly 32'h42000018).
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers = 0, count = 0, out_valid = 0, in_ready = 1.
  - Storage contents are don't-care.
  - rst has priority over flush, push and pop.
- Push: in_valid && in_ready at an edge writes {in_pc, in_instr, decode(in_instr)} into the tail entry, then advances tail mod DEPTH.
- Decode is combinational on in_instr; the result is stored registered.
- Pop: out_valid && out_ready at an edge advances head mod DEPTH.
- All out_* fields are read combinationally from the head entry. When out_valid = 0 every decoded out_* field and out_instr are forced to 0.
- Latency: push into an empty queue at edge t → out_valid = 1 after edge t; there is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged.
- Simultaneous push and pop when count = DEPTH: the push is blocked because in_ready = 0; the pop proceeds and count becomes DEPTH-1.
- Simultaneous push and pop when empty: the pop is ignored; the push proceeds and count becomes 1.
- Flush at an edge: head = tail = 0 and count = 0. Any push or pop in the same cycle is discarded. in_ready = 1 in the next cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits. full/empty are derived from count, not pointer equality.
- Decode rules (MIPS32 subset, 57 instructions + ERET):
  - regwrite is set for:
    - R-type ALU ops, shifts, JALR, MFHI and MFLO;
    - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI;
    - loads;
    - JAL, BGEZAL/BLTZAL, MFC0;
    - MUL when ENABLE_MUL = 1.
  - BNE, stores, branches other than the -AL forms, and MT* do NOT set regwrite.
  - regdst:
    - 1 for R-type and MUL;
    - 2 for JAL/BGEZAL/BLTZAL;
    - 0 otherwise.
    - JALR uses rd (1).
  - alusrc is set for immediate ALU ops, loads and stores.
  - out_branch is set for BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ/BGEZAL/BLTZAL.
  - out_ex_ri is set for any encoding outside the legal set. When out_ex_ri = 1, all other decoded fields are 0.

Test Plan:
- Reset, then push ADDIU 0x24020005 at pc 0xBFC00000 → after 1 edge: out_valid = 1, out_regwrite = 1, out_regdst = 0, out_alusrc = 1, count = 1.
- Hold out_ready = 0 and push DEPTH = 4 words → in_ready = 0 and count = 4 after edge 4; a 5th push attempt is ignored. Then pop+push in the same cycle → count stays 4 → 3 → 4 across two cycles, and FIFO order is preserved across wrap.
- Push BNE 0x14430002 → out_branch = 1, out_regwrite = 0. Push JAL 0x0C000010 → out_jump = 1, out_regdst = 2, out_regwrite = 1.
- Push 0x70430802 with ENABLE_MUL = 0 → out_ex_ri = 1, all other decoded fields 0. With ENABLE_MUL = 1 → out_regwrite = 1, out_regdst = 1, out_ex_ri = 0.
- Fill 3 entries, assert flush together with in_valid and out_ready → next cycle count = 0, out_valid = 0, in_ready = 1, and the pushed word is not present.
- Push 0x42000018, 0x0000000C and 0x0000000D → head sequence shows out_eret, then out_ex_sys, then out_ex_bp, each = 1 alone. Assert rst mid-stream → count = 0 and out_valid = 0 after the edge.

Source files
------------

// File: rtl/decode_queue_if.sv
// Handshake bundle between the fetch side, the decode queue and the issue side.
interface decode_queue_if #(
    parameter int unsigned PC_W = 32
);
    // Fetch-side handshake
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    // Issue-side handshake and decoded head bundle
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_regwrite;
    logic [1:0]      out_regdst;
    logic            out_alusrc;
    logic            out_branch;
    logic            out_jump;
    logic            out_jr;
    logic [3:0]      out_memwrite;
    logic [1:0]      out_memread;
    logic            out_load_signed;
    logic            out_hilowrite;
    logic            out_cp0write;
    logic            out_cp0read;
    logic            out_ex_ri;
    logic            out_ex_bp;
    logic            out_ex_sys;
    logic            out_eret;

    // Producer/consumer side
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_regwrite, out_regdst,
               out_alusrc, out_branch, out_jump, out_jr, out_memwrite, out_memread,
               out_load_signed, out_hilowrite, out_cp0write, out_cp0read,
               out_ex_ri, out_ex_bp, out_ex_sys, out_eret
    );

    // Queue side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_regwrite, out_regdst,
               out_alusrc, out_branch, out_jump, out_jr, out_memwrite, out_memread,
               out_load_signed, out_hilowrite, out_cp0write, out_cp0read,
               out_ex_ri, out_ex_bp, out_ex_sys, out_eret
    );
endinterface

// File: rtl/decode_queue.sv
// Decode-on-entry instruction queue: decodes MIPS32 words as they are pushed and
// buffers the control bundles in a DEPTH-entry FIFO for the issue stage.
module decode_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter bit          ENABLE_MUL = 1'b0,
    parameter int unsigned PC_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    decode_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jr;
        logic [3:0] memwrite;
        logic [1:0] memread;
        logic       load_signed;
        logic       hilowrite;
        logic       cp0write;
        logic       cp0read;
        logic       ex_ri;
        logic       ex_bp;
        logic       ex_sys;
        logic       eret;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        ctrl_t           ctrl;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    ctrl_t              dec;
    entry_t             rd;

    // Decode one word; anything outside the legal subset yields ex_ri alone.
    function automatic ctrl_t decode(input logic [31:0] ir);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        c  = '0;
        op = ir[31:26];
        fn = ir[5:0];
        rs = ir[25:21];
        rt = ir[20:16];
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12: begin
                        c.regwrite = 1'b1;
                        c.regdst   = 2'd1;
                    end
                    6'h08: begin
                        c.jr     = 1'b1;
                        c.regdst = 2'd1;
                    end
                    6'h09: begin
                        c.jr       = 1'b1;
                        c.regwrite = 1'b1;
                        c.regdst   = 2'd1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        c.hilowrite = 1'b1;
                        c.regdst    = 2'd1;
                    end
                    6'h0C:   c.ex_sys = 1'b1;
                    6'h0D:   c.ex_bp  = 1'b1;
                    default: c.ex_ri  = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: c.branch = 1'b1;
                    5'h10, 5'h11: begin
                        c.branch   = 1'b1;
                        c.regwrite = 1'b1;
                        c.regdst   = 2'd2;
                    end
                    default: c.ex_ri = 1'b1;
                endcase
            end
            6'h02: c.jump = 1'b1;
            6'h03: begin
                c.jump     = 1'b1;
                c.regwrite = 1'b1;
                c.regdst   = 2'd2;
            end
            6'h04, 6'h05, 6'h06, 6'h07: c.branch = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c.regwrite    = 1'b1;
                c.alusrc      = 1'b1;
                c.load_signed = (op == 6'h20) || (op == 6'h21) || (op == 6'h23);
                case (op)
                    6'h20, 6'h24: c.memread = 2'd1;
                    6'h21, 6'h25: c.memread = 2'd2;
                    default:      c.memread = 2'd3;
                endcase
            end
            6'h28: begin
                c.alusrc   = 1'b1;
                c.memwrite = 4'b0001;
            end
            6'h29: begin
                c.alusrc   = 1'b1;
                c.memwrite = 4'b0011;
            end
            6'h2B: begin
                c.alusrc   = 1'b1;
                c.memwrite = 4'b1111;
            end
            6'h10: begin
                if (ir == ERET_WORD) begin
                    c.eret = 1'b1;
                end else if (rs == 5'h00) begin
                    c.regwrite = 1'b1;
                    c.cp0read  = 1'b1;
                end else if (rs == 5'h04) begin
                    c.cp0write = 1'b1;
                end else begin
                    c.ex_ri = 1'b1;
                end
            end
            6'h1C: begin
                if (ENABLE_MUL && (fn == 6'h02)) begin
                    c.regwrite = 1'b1;
                    c.regdst   = 2'd1;
                end else begin
                    c.ex_ri = 1'b1;
                end
            end
            default: c.ex_ri = 1'b1;
        endcase
        return c;
    endfunction

    // Occupancy flags and qualified handshakes
    always_comb begin
        full          = (count == CNT_W'(DEPTH));
        empty         = (count == '0);
        push          = bus.in_valid && !full;
        pop           = bus.out_ready && !empty;
        bus.in_ready  = !full;
        bus.out_valid = !empty;
        dec           = decode(bus.in_instr);
    end

    // Pointer and occupancy update; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset or flush
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[tail] <= '{pc: PC_W'(bus.in_pc), instr: bus.in_instr, ctrl: dec};
        end
    end

    // Head read, blanked while the queue is empty
    always_comb begin
        rd = '0;
        if (!empty) rd = mem[head];
    end

    // Head bundle fan-out
    always_comb begin
        bus.out_pc          = rd.pc;
        bus.out_instr       = rd.instr;
        bus.out_regwrite    = rd.ctrl.regwrite;
        bus.out_regdst      = rd.ctrl.regdst;
        bus.out_alusrc      = rd.ctrl.alusrc;
        bus.out_branch      = rd.ctrl.branch;
        bus.out_jump        = rd.ctrl.jump;
        bus.out_jr          = rd.ctrl.jr;
        bus.out_memwrite    = rd.ctrl.memwrite;
        bus.out_memread     = rd.ctrl.memread;
        bus.out_load_signed = rd.ctrl.load_signed;
        bus.out_hilowrite   = rd.ctrl.hilowrite;
        bus.out_cp0write    = rd.ctrl.cp0write;
        bus.out_cp0read     = rd.ctrl.cp0read;
        bus.out_ex_ri       = rd.ctrl.ex_ri;
        bus.out_ex_bp       = rd.ctrl.ex_bp;
        bus.out_ex_sys      = rd.ctrl.ex_sys;
        bus.out_eret        = rd.ctrl.eret;
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one instance without and one with the MUL extension.
module tb_decode_queue;
    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    int         tests;
    int         fails;

    decode_queue_if #(.PC_W(32)) bus0 ();
    decode_queue_if #(.PC_W(32)) bus1 ();

    decode_queue #(.DEPTH(4), .ENABLE_MUL(1'b0), .PC_W(32)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0.slave), .count(cnt0)
    );
    decode_queue #(.DEPTH(4), .ENABLE_MUL(1'b1), .PC_W(32)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1.slave), .count(cnt1)
    );

    // Decoded fields packed as {regwrite, regdst, alusrc, branch, jump, jr,
    // memwrite, memread, load_signed, hilowrite, cp0write, cp0read, ex_ri, ex_bp, ex_sys, eret}
    logic [20:0] f0;
    logic [20:0] f1;
    assign f0 = {bus0.out_regwrite, bus0.out_regdst, bus0.out_alusrc, bus0.out_branch,
                 bus0.out_jump, bus0.out_jr, bus0.out_memwrite, bus0.out_memread,
                 bus0.out_load_signed, bus0.out_hilowrite, bus0.out_cp0write, bus0.out_cp0read,
                 bus0.out_ex_ri, bus0.out_ex_bp, bus0.out_ex_sys, bus0.out_eret};
    assign f1 = {bus1.out_regwrite, bus1.out_regdst, bus1.out_alusrc, bus1.out_branch,
                 bus1.out_jump, bus1.out_jr, bus1.out_memwrite, bus1.out_memread,
                 bus1.out_load_signed, bus1.out_hilowrite, bus1.out_cp0write, bus1.out_cp0read,
                 bus1.out_ex_ri, bus1.out_ex_bp, bus1.out_ex_sys, bus1.out_eret};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_instr = '0; bus0.in_pc = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_instr = '0; bus1.in_pc = '0; bus1.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("rst_out_instr", bus0.out_instr, 32'd0);
        chk("rst_fields", 32'(f0), 32'd0);

        // ADDIU into an empty queue appears after one edge
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0005; bus0.in_pc = 32'hBFC0_0000;
        step();
        bus0.in_valid = 1'b0;
        chk("addiu_valid", 32'(bus0.out_valid), 32'd1);
        chk("addiu_regwrite", 32'(bus0.out_regwrite), 32'd1);
        chk("addiu_regdst", 32'(bus0.out_regdst), 32'd0);
        chk("addiu_alusrc", 32'(bus0.out_alusrc), 32'd1);
        chk("addiu_fields", 32'(f0), 32'h12_0000);
        chk("addiu_count", 32'(cnt0), 32'd1);
        chk("addiu_pc", bus0.out_pc, 32'hBFC0_0000);
        chk("addiu_instr", bus0.out_instr, 32'h2402_0005);
        bus0.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0;
        chk("pop1_count", 32'(cnt0), 32'd0);
        chk("pop1_valid", 32'(bus0.out_valid), 32'd0);

        // Fill to DEPTH with pointers offset by one so the tail wraps
        for (int i = 0; i < 4; i++) begin
            bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0010 + 32'(i); bus0.in_pc = 32'h100 + 32'(4 * i);
            step();
            chk("fill_count", 32'(cnt0), 32'(i + 1));
        end
        chk("full_in_ready", 32'(bus0.in_ready), 32'd0);
        bus0.in_instr = 32'hDEAD_BEEF;
        step();
        chk("full_push_ignored", 32'(cnt0), 32'd4);
        chk("full_head", bus0.out_instr, 32'h2402_0010);
        // Push+pop while full: push blocked, pop proceeds
        bus0.out_ready = 1'b1; bus0.in_instr = 32'h2402_0014;
        step();
        chk("fullpp_count", 32'(cnt0), 32'd3);
        chk("fullpp_head", bus0.out_instr, 32'h2402_0011);
        bus0.out_ready = 1'b0;
        step();
        chk("refill_count", 32'(cnt0), 32'd4);
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        step();
        chk("drain_head2", bus0.out_instr, 32'h2402_0012);
        chk("drain_count3", 32'(cnt0), 32'd3);
        // Push+pop at partial occupancy leaves count unchanged
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0015;
        step();
        bus0.in_valid = 1'b0;
        chk("midpp_count", 32'(cnt0), 32'd3);
        chk("drain_head3", bus0.out_instr, 32'h2402_0013);
        step();
        chk("drain_head4", bus0.out_instr, 32'h2402_0014);
        step();
        chk("drain_head5", bus0.out_instr, 32'h2402_0015);
        chk("drain_pc5", bus0.out_pc, 32'h10C);
        step();
        chk("drain_empty", 32'(bus0.out_valid), 32'd0);

        // Push+pop on empty: pop ignored, push lands (BNE)
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h1443_0002;
        step();
        chk("bne_count", 32'(cnt0), 32'd1);
        chk("bne_branch", 32'(bus0.out_branch), 32'd1);
        chk("bne_regwrite", 32'(bus0.out_regwrite), 32'd0);
        chk("bne_fields", 32'(f0), 32'h01_0000);
        bus0.in_instr = 32'h0C00_0010;
        step();
        bus0.in_valid = 1'b0;
        chk("jal_count", 32'(cnt0), 32'd1);
        chk("jal_jump", 32'(bus0.out_jump), 32'd1);
        chk("jal_regdst", 32'(bus0.out_regdst), 32'd2);
        chk("jal_regwrite", 32'(bus0.out_regwrite), 32'd1);
        chk("jal_fields", 32'(f0), 32'h18_8000);
        step();
        bus0.out_ready = 1'b0;
        chk("jal_popped", 32'(cnt0), 32'd0);

        // MUL on both instances
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h7043_0802;
        bus1.in_valid = 1'b1; bus1.in_instr = 32'h7043_0802;
        step();
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        chk("mul0_ex_ri", 32'(bus0.out_ex_ri), 32'd1);
        chk("mul0_fields", 32'(f0), 32'h00_0008);
        chk("mul1_regwrite", 32'(bus1.out_regwrite), 32'd1);
        chk("mul1_regdst", 32'(bus1.out_regdst), 32'd1);
        chk("mul1_ex_ri", 32'(bus1.out_ex_ri), 32'd0);
        chk("mul1_fields", 32'(f1), 32'h14_0000);
        chk("mul1_count", 32'(cnt1), 32'd1);
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;

        // Load and store decode
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h9043_0000;
        step();
        bus0.in_instr = 32'hAC43_0000;
        step();
        bus0.in_valid = 1'b0;
        chk("lbu_fields", 32'(f0), 32'h12_0100);
        bus0.out_ready = 1'b1;
        step();
        chk("sw_fields", 32'(f0), 32'h02_3C00);
        step();
        bus0.out_ready = 1'b0;

        // Flush with concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0020 + 32'(i); bus0.in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        chk("preflush_count", 32'(cnt0), 32'd3);
        flush = 1'b1; bus0.in_instr = 32'hAAAA_5555; bus0.out_ready = 1'b1;
        step();
        flush = 1'b0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        chk("flush_count", 32'(cnt0), 32'd0);
        chk("flush_valid", 32'(bus0.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("flush_instr", bus0.out_instr, 32'd0);
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0077;
        step();
        bus0.in_valid = 1'b0;
        chk("postflush_head", bus0.out_instr, 32'h2402_0077);
        chk("postflush_count", 32'(cnt0), 32'd1);
        bus0.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0;

        // ERET, SYSCALL, BREAK in order, each flag alone
        bus0.in_valid = 1'b1; bus0.in_instr = 32'h4200_0018;
        step();
        bus0.in_instr = 32'h0000_000C;
        step();
        bus0.in_instr = 32'h0000_000D;
        step();
        bus0.in_valid = 1'b0;
        chk("eret_fields", 32'(f0), 32'h00_0001);
        bus0.out_ready = 1'b1;
        step();
        chk("sys_fields", 32'(f0), 32'h00_0002);
        step();
        chk("bp_fields", 32'(f0), 32'h00_0004);
        bus0.out_ready = 1'b0;

        // Reset mid-stream overrides a concurrent push
        chk("prerst_count", 32'(cnt0), 32'd1);
        rst = 1'b1; bus0.in_valid = 1'b1; bus0.in_instr = 32'h2402_0099;
        step();
        rst = 1'b0; bus0.in_valid = 1'b0;
        chk("midrst_count", 32'(cnt0), 32'd0);
        chk("midrst_valid", 32'(bus0.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus0.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
